clk_div_monitor: RTL and testbench

Self-checking frequency/duty monitor that sits directly downstream of the fixed clock dividers, such as the divide-by-5 stage. It samples the divided clock in the source clock domain and measures each period and high time in source-clock cycles. It compares both against parameterised limits and reports per-period measurements, a lock indication and sticky error flags. It lets the divider be checked in-system rather than only by bench timing checks.

---
 rtl/clk_div_monitor.sv | 140 ++++++++++++++
 tb/tb_clk_div_monitor.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Measures the period and high time of a divided clock (clk_in) in source
//   clock (clk) cycles. It checks both against parameterised limits and
//   reports a lock indication plus sticky error flags.
//
// Ports
//   clk        source clock; clk_in is sampled on its rising edge only
//   rst        synchronous, active-high reset
//   clk_in     divided clock under check
//   err_clr    clears period_err / high_err (a simultaneous set wins)
//   meas_valid one-cycle pulse when period_cnt / high_cnt are updated
//   period_cnt last measured period, in clk cycles
//   high_cnt   last measured high time, in clk cycles
//   locked     LOCK_N consecutive good periods, with no error since
//   period_err sticky: wrong period or timeout seen
//   high_err   sticky: high time outside [HIGH_MIN, HIGH_MAX] seen
module clk_div_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_PERIOD  = 5,
  parameter int unsigned HIGH_MIN    = 2,
  parameter int unsigned HIGH_MAX    = 3,
  parameter int unsigned LOCK_N      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             err_clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             locked,
  output logic             period_err,
  output logic             high_err
);

  localparam int unsigned GR_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] HMIN_C  = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] HMAX_C  = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_MAX - CNT_W'(1);
  localparam logic [GR_W-1:0]  LOCK_C  = GR_W'(LOCK_N);

  typedef enum logic {SEEK, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;
  logic [GR_W-1:0]        good_run;
  logic [GR_W-1:0]        good_next;
  logic                   meas_ev;
  logic                   period_ok;
  logic                   high_ok;
  logic                   timeout;
  logic                   set_p;
  logic                   set_h;

  always_comb begin
    s         = sync[SYNC_STAGES-1];
    rise      = s & ~s_d;
    meas_ev   = (state == MEASURE) && rise;
    period_ok = (cnt == EXP_C);
    high_ok   = (hcnt >= HMIN_C) && (hcnt <= HMAX_C);
    good_next = (good_run == LOCK_C) ? good_run : good_run + GR_W'(1);
    // Fires on the edge where cnt would step to all-ones; a rise on that
    // same cycle takes priority and yields a normal measurement instead.
    timeout   = (state == MEASURE) && !rise && (cnt == TO_LIM);
    set_p     = (meas_ev && !period_ok) || timeout;
    set_h     = meas_ev && !high_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEEK;
      sync       <= '0;
      s_d        <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      good_run   <= '0;
      meas_valid <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      locked     <= 1'b0;
      period_err <= 1'b0;
      high_err   <= 1'b0;
    end else begin
      sync[0] <= clk_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      s_d        <= s;
      meas_valid <= 1'b0;
      period_err <= (period_err & ~err_clr) | set_p;
      high_err   <= (high_err & ~err_clr) | set_h;

      unique case (state)
        SEEK: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            hcnt  <= CNT_W'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_cnt <= cnt;
            high_cnt   <= hcnt;
            meas_valid <= 1'b1;
            cnt        <= CNT_W'(1);
            hcnt       <= CNT_W'(1);
            if (period_ok && high_ok) begin
              good_run <= good_next;
              locked   <= (good_next == LOCK_C);
            end else begin
              good_run <= '0;
              locked   <= 1'b0;
            end
          end else if (timeout) begin
            good_run <= '0;
            locked   <= 1'b0;
            state    <= SEEK;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (s && (hcnt != CNT_MAX)) begin
              hcnt <= hcnt + CNT_W'(1);
            end
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed testbench for clk_div_monitor with default parameters
// (CNT_W=8, EXP_PERIOD=5, HIGH_MIN=2, HIGH_MAX=3, LOCK_N=4, SYNC_STAGES=2).
module tb_clk_div_monitor;

  logic       clk;
  logic       rst;
  logic       clk_in;
  logic       err_clr;
  logic       meas_valid;
  logic [7:0] period_cnt;
  logic [7:0] high_cnt;
  logic       locked;
  logic       period_err;
  logic       high_err;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [7:0] p;
    logic [7:0] h;
    logic       l;
    logic       pe;
    logic       he;
  } meas_t;

  meas_t mv_q[$];

  clk_div_monitor #(
    .CNT_W(8),
    .EXP_PERIOD(5),
    .HIGH_MIN(2),
    .HIGH_MAX(3),
    .LOCK_N(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_in(clk_in),
    .err_clr(err_clr),
    .meas_valid(meas_valid),
    .period_cnt(period_cnt),
    .high_cnt(high_cnt),
    .locked(locked),
    .period_err(period_err),
    .high_err(high_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log every measurement with the outputs seen alongside it.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      meas_t m;
      m.cyc = cyc;
      m.p   = period_cnt;
      m.h   = high_cnt;
      m.l   = locked;
      m.pe  = period_err;
      m.he  = high_err;
      mv_q.push_back(m);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    clk_in  = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mv_q.delete();
  endtask

  // Starts and ends on a negedge: hi cycles high, then lo cycles low.
  task automatic run(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      clk_in = 1'b1;
      repeat (hi) @(negedge clk);
      clk_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [20:0] got;
    do_reset();
    got = {meas_valid, period_cnt, high_cnt, locked, period_err, high_err};
    cmp_cnt++;
    if (got !== 21'h0) begin
      mis_cnt++;
      $display("FAIL reset_state: got %h expected %h", got, 21'h0);
    end
  endtask

  task automatic test_ideal();
    logic [18:0] got, exp;
    do_reset();
    run(8, 3, 2);
    repeat (5) @(negedge clk);
    cmp_cnt++;
    if (mv_q.size() !== 7) begin
      mis_cnt++;
      $display("FAIL ideal_count: got %0d expected %0d", mv_q.size(), 7);
    end
    for (int i = 0; i < mv_q.size(); i++) begin
      got = {mv_q[i].p, mv_q[i].h, mv_q[i].l, mv_q[i].pe, mv_q[i].he};
      exp = {8'd5, 8'd3, (i >= 3), 1'b0, 1'b0};
      cmp_cnt++;
      if (got !== exp) begin
        mis_cnt++;
        $display("FAIL ideal_meas[%0d]: got %h expected %h", i, got, exp);
      end
      if (i > 0) begin
        cmp_cnt++;
        if (mv_q[i].cyc - mv_q[i-1].cyc !== 5) begin
          mis_cnt++;
          $display("FAIL ideal_interval[%0d]: got %0d expected %0d", i,
                   mv_q[i].cyc - mv_q[i-1].cyc, 5);
        end
      end
    end
  endtask

  // 50% duty divide-by-5 output: rises on a clk negedge, falls 2.5 cycles
  // later (1 ns skew keeps the fall clear of the sampling edge).
  task automatic test_div5();
    logic [7:0] h0;
    logic       h_ok;
    logic [10:0] got, exp;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      clk_in = 1'b1;
      #26;
      clk_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    cmp_cnt++;
    if (mv_q.size() !== 7) begin
      mis_cnt++;
      $display("FAIL div5_count: got %0d expected %0d", mv_q.size(), 7);
    end
    h0 = (mv_q.size() > 0) ? mv_q[0].h : 8'hxx;
    h_ok = (h0 === 8'd2) || (h0 === 8'd3);
    cmp_cnt++;
    if (h_ok !== 1'b1) begin
      mis_cnt++;
      $display("FAIL div5_high_range: got %0d expected 2 or 3", h0);
    end
    for (int i = 0; i < mv_q.size(); i++) begin
      got = {mv_q[i].p, mv_q[i].l, mv_q[i].pe, mv_q[i].he};
      exp = {8'd5, (i >= 3), 1'b0, 1'b0};
      cmp_cnt++;
      if (got !== exp || mv_q[i].h !== h0) begin
        mis_cnt++;
        $display("FAIL div5_meas[%0d]: got %h/h=%0d expected %h/h=%0d", i, got,
                 mv_q[i].h, exp, h0);
      end
    end
  endtask

  task automatic test_stretch();
    logic [18:0] got, exp;
    do_reset();
    run(6, 3, 2);
    run(1, 3, 3);
    run(5, 3, 2);
    run(1, 3, 2);
    repeat (5) @(negedge clk);
    cmp_cnt++;
    if (mv_q.size() !== 12) begin
      mis_cnt++;
      $display("FAIL stretch_count: got %0d expected %0d", mv_q.size(), 12);
    end
    for (int i = 0; i < mv_q.size(); i++) begin
      if (i < 6)       exp = {8'd5, 8'd3, (i >= 3), 1'b0, 1'b0};
      else if (i == 6) exp = {8'd6, 8'd3, 1'b0, 1'b1, 1'b0};
      else             exp = {8'd5, 8'd3, (i >= 10), 1'b1, 1'b0};
      got = {mv_q[i].p, mv_q[i].h, mv_q[i].l, mv_q[i].pe, mv_q[i].he};
      cmp_cnt++;
      if (got !== exp) begin
        mis_cnt++;
        $display("FAIL stretch_meas[%0d]: got %h expected %h", i, got, exp);
      end
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    got = {period_cnt, high_cnt, locked, period_err, high_err};
    exp = {8'd5, 8'd3, 1'b1, 1'b0, 1'b0};
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL stretch_err_clr: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_timeout();
    int waited;
    int last_cyc;
    logic [18:0] got, exp;
    do_reset();
    run(6, 3, 2);
    cmp_cnt++;
    if ({locked, period_err} !== 2'b10) begin
      mis_cnt++;
      $display("FAIL timeout_pre: got %b expected %b", {locked, period_err}, 2'b10);
    end
    last_cyc = (mv_q.size() > 0) ? mv_q[mv_q.size()-1].cyc : 0;
    waited = 0;
    while (period_err !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    cmp_cnt++;
    if (period_err !== 1'b1) begin
      mis_cnt++;
      $display("FAIL timeout_wait: got period_err=%b expected 1 within 400 cycles",
               period_err);
    end
    cmp_cnt++;
    if (cyc - last_cyc !== 254) begin
      mis_cnt++;
      $display("FAIL timeout_latency: got %0d expected %0d", cyc - last_cyc, 254);
    end
    got = {period_cnt, high_cnt, locked, meas_valid, high_err};
    exp = {8'd5, 8'd3, 1'b0, 1'b0, 1'b0};
    cmp_cnt++;
    if (got !== exp || mv_q.size() !== 5) begin
      mis_cnt++;
      $display("FAIL timeout_state: got %h n=%0d expected %h n=5", got, mv_q.size(), exp);
    end
    run(4, 3, 2);
    repeat (5) @(negedge clk);
    cmp_cnt++;
    if (mv_q.size() !== 8) begin
      mis_cnt++;
      $display("FAIL timeout_recover_count: got %0d expected %0d", mv_q.size(), 8);
    end
    for (int i = 5; i < mv_q.size(); i++) begin
      got = {mv_q[i].p, mv_q[i].h, mv_q[i].l, mv_q[i].pe, mv_q[i].he};
      exp = {8'd5, 8'd3, 1'b0, 1'b1, 1'b0};
      cmp_cnt++;
      if (got !== exp) begin
        mis_cnt++;
        $display("FAIL timeout_recover[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_high_err();
    logic [18:0] got, exp;
    do_reset();
    run(4, 4, 1);
    // Next rise produces a bad measurement two edges later; err_clr is
    // raised so it is sampled on that same edge.
    clk_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    got = {8'd0, high_cnt, meas_valid, period_err, high_err};
    exp = {8'd0, 8'd4, 1'b1, 1'b0, 1'b1};
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL high_err_set_wins: got %h expected %h", got, exp);
    end
    @(negedge clk);
    clk_in = 1'b0;
    repeat (4) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    cmp_cnt++;
    if ({period_err, high_err} !== 2'b00) begin
      mis_cnt++;
      $display("FAIL high_err_clear: got %b expected %b", {period_err, high_err}, 2'b00);
    end
    cmp_cnt++;
    if (mv_q.size() !== 4) begin
      mis_cnt++;
      $display("FAIL high_err_count: got %0d expected %0d", mv_q.size(), 4);
    end
    for (int i = 0; i < mv_q.size(); i++) begin
      got = {mv_q[i].p, mv_q[i].h, mv_q[i].l, mv_q[i].pe, mv_q[i].he};
      exp = {8'd5, 8'd4, 1'b0, 1'b0, 1'b1};
      cmp_cnt++;
      if (got !== exp) begin
        mis_cnt++;
        $display("FAIL high_err_meas[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    int c2;
    logic [20:0] gotr;
    logic [18:0] got, exp;
    do_reset();
    run(6, 3, 2);
    clk_in = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (locked !== 1'b1) begin
      mis_cnt++;
      $display("FAIL rst_pre_locked: got %b expected %b", locked, 1'b1);
    end
    clk_in = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    gotr = {meas_valid, period_cnt, high_cnt, locked, period_err, high_err};
    cmp_cnt++;
    if (gotr !== 21'h0) begin
      mis_cnt++;
      $display("FAIL rst_mid_outputs: got %h expected %h", gotr, 21'h0);
    end
    mv_q.delete();
    @(negedge clk);
    run(1, 3, 2);
    c2 = cyc;
    run(2, 3, 2);
    repeat (5) @(negedge clk);
    cmp_cnt++;
    if (mv_q.size() !== 2) begin
      mis_cnt++;
      $display("FAIL rst_mid_count: got %0d expected %0d", mv_q.size(), 2);
    end
    cmp_cnt++;
    if (mv_q.size() > 0 && !(mv_q[0].cyc > c2)) begin
      mis_cnt++;
      $display("FAIL rst_mid_first_meas: got cycle %0d expected after %0d", mv_q[0].cyc, c2);
    end
    for (int i = 0; i < mv_q.size(); i++) begin
      got = {mv_q[i].p, mv_q[i].h, mv_q[i].l, mv_q[i].pe, mv_q[i].he};
      exp = {8'd5, 8'd3, 1'b0, 1'b0, 1'b0};
      cmp_cnt++;
      if (got !== exp) begin
        mis_cnt++;
        $display("FAIL rst_mid_meas[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    clk_in  = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_ideal();
    test_div5();
    test_stretch();
    test_timeout();
    test_high_err();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
